mpadder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-precision adder/subtractor (`mpadder`) between up to four requesters, e.g. Montgomery multiplier and exponentiation control. It latches the winning requester's operands and drives the adder's one-cycle `start` handshake. It captures the result on the adder's `done` pulse and returns it to the owning requester. A watchdog terminates an operation if `done` never arrives.

---
 rtl/mpadder_arbiter.sv | 126 ++++++++++++
 tb/tb_mpadder_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpadder_arbiter.sv
// Round-robin arbiter and sequencer sharing one multi-precision adder/subtractor
// between N_REQ requesters, with a watchdog that aborts a missing add_done.
module mpadder_arbiter #(
   parameter int unsigned WIDTH   = 1027,
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_sub,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH:0]         rsp_result,
   output logic                   rsp_err,
   output logic                   add_start,
   output logic                   add_subtract,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   input  logic [WIDTH:0]         add_result,
   input  logic                   add_done,
   output logic                   busy
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t        state;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] owner;
   logic [IW-1:0] grant_idx;
   logic [IW-1:0] scan_idx;
   logic          grant_found;
   logic [7:0]    wd_cnt;

   // Search starts one past the last winner and wraps modulo N_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_idx = IW'((32'(last_grant) + 32'd1 + k) % N_REQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         last_grant   <= IW'(N_REQ - 1);
         owner        <= '0;
         wd_cnt       <= '0;
         rsp_valid    <= '0;
         rsp_result   <= '0;
         rsp_err      <= 1'b0;
         add_start    <= 1'b0;
         add_subtract <= 1'b0;
         add_a        <= '0;
         add_b        <= '0;
         busy         <= 1'b0;
      end else begin
         rsp_valid <= '0;
         add_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  owner        <= grant_idx;
                  last_grant   <= grant_idx;
                  add_a        <= req_a[grant_idx*WIDTH +: WIDTH];
                  add_b        <= req_b[grant_idx*WIDTH +: WIDTH];
                  add_subtract <= req_sub[grant_idx];
                  add_start    <= 1'b1;
                  busy         <= 1'b1;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wd_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               // add_done takes priority over a coinciding timeout.
               if (add_done) begin
                  rsp_result       <= add_result;
                  rsp_err          <= 1'b0;
                  rsp_valid[owner] <= 1'b1;
                  state            <= S_RESP;
               end else if (wd_cnt == 8'(TIMEOUT)) begin
                  rsp_result       <= '0;
                  rsp_err          <= 1'b1;
                  rsp_valid[owner] <= 1'b1;
                  state            <= S_RESP;
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
            end
            S_RESP: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Randomized self-checking bench for mpadder_arbiter: a transaction-timeline
// reference model predicts grants, adder handshake and responses every cycle.
module tb_mpadder_arbiter;

   localparam int W  = 16;
   localparam int N  = 3;
   localparam int TO = 15;

   typedef struct packed {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_sub;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   rsp_valid;
   logic [W:0]     rsp_result;
   logic           rsp_err;
   logic           add_start;
   logic           add_subtract;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic [W:0]     add_result;
   logic           add_done;
   logic           busy;

   mpadder_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_sub     (req_sub),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_result  (rsp_result),
      .rsp_err     (rsp_err),
      .add_start   (add_start),
      .add_subtract(add_subtract),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_result  (add_result),
      .add_done    (add_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: cycle numbers of the in-flight operation's events.
   int         cyc      = 0;
   int         m_last   = N - 1;
   int         m_owner  = 0;
   int         m_issue  = -1;
   int         m_rsp    = -1;
   int         m_free   = 0;
   int         m_k      = 0;
   op_t        m_op;
   logic [W:0] m_res;
   logic       m_err;

   // Adder model state.
   int         done_cyc  = -1;
   logic [W:0] adder_res = '0;

   // Stimulus knobs.
   int   next_k     = -1;
   logic rand_valid = 1'b0;
   logic stray_en   = 1'b0;

   op_t q[N][$];
   int  dut_log[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_zero();
      check("rst_req_ready",  64'(req_ready),    64'(0));
      check("rst_rsp_valid",  64'(rsp_valid),    64'(0));
      check("rst_rsp_result", 64'(rsp_result),   64'(0));
      check("rst_rsp_err",    64'(rsp_err),      64'(0));
      check("rst_add_start",  64'(add_start),    64'(0));
      check("rst_add_sub",    64'(add_subtract), 64'(0));
      check("rst_add_a",      64'(add_a),        64'(0));
      check("rst_add_b",      64'(add_b),        64'(0));
      check("rst_busy",       64'(busy),         64'(0));
   endtask

   task automatic model_reset();
      m_last   = N - 1;
      m_issue  = -1;
      m_rsp    = -1;
      m_free   = 0;
      done_cyc = -1;
   endtask

   function automatic logic [W:0] arith(input op_t op);
      if (op.sub) return {1'b0, op.a} - {1'b0, op.b};
      return {1'b0, op.a} + {1'b0, op.b};
   endfunction

   function automatic int pick_k();
      int r;
      if (next_k >= 0) return next_k;
      r = $urandom_range(9);
      if (r == 0) return 0;
      if (r == 1) return TO + 1;
      return $urandom_range(1, 4);
   endfunction

   task automatic step();
      logic         idle;
      logic         found;
      int           win;
      int           idx;
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_rsp;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0) begin
            req_valid[i]       = !rand_valid || ($urandom_range(3) != 0);
            req_sub[i]         = q[i][0].sub;
            req_a[i*W +: W]    = q[i][0].a;
            req_b[i*W +: W]    = q[i][0].b;
         end else begin
            req_valid[i]       = 1'b0;
            req_sub[i]         = 1'($urandom);
            req_a[i*W +: W]    = W'($urandom);
            req_b[i*W +: W]    = W'($urandom);
         end
      end
      if (cyc == done_cyc) begin
         add_done   = 1'b1;
         add_result = adder_res;
      end else if (stray_en && cyc >= m_free && $urandom_range(1) == 0) begin
         add_done   = 1'b1;
         add_result = (W+1)'($urandom);
      end else begin
         add_done   = 1'b0;
         add_result = (W+1)'($urandom);
      end
      #1;
      idle  = (cyc >= m_free);
      found = 1'b0;
      win   = 0;
      if (idle) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_last + 1 + k) % N;
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
      exp_ready = '0;
      if (found) exp_ready[win] = 1'b1;
      exp_rsp = '0;
      if (cyc == m_rsp) exp_rsp[m_owner] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("busy",      64'(busy),      64'(!idle));
      check("add_start", 64'(add_start), 64'(cyc == m_issue));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      if (cyc == m_rsp) begin
         check("rsp_result", 64'(rsp_result), 64'(m_res));
         check("rsp_err",    64'(rsp_err),    64'(m_err));
      end
      if (m_issue >= 0 && cyc >= m_issue && cyc <= m_rsp) begin
         check("add_a",        64'(add_a),        64'(m_op.a));
         check("add_b",        64'(add_b),        64'(m_op.b));
         check("add_subtract", 64'(add_subtract), 64'(m_op.sub));
      end
      for (int i = 0; i < N; i++) begin
         if (req_ready[i]) dut_log.push_back(i);
      end
      if (add_start) begin
         adder_res = add_subtract ? ({1'b0, add_a} - {1'b0, add_b})
                                  : ({1'b0, add_a} + {1'b0, add_b});
         done_cyc  = (m_k > 0) ? cyc + m_k : -1;
      end
      if (found) begin
         m_owner = win;
         m_last  = win;
         m_op    = q[win].pop_front();
         m_k     = pick_k();
         m_issue = cyc + 1;
         m_rsp   = (m_k > 0) ? cyc + 2 + m_k : cyc + TO + 3;
         m_free  = m_rsp + 1;
         m_err   = (m_k == 0);
         m_res   = m_err ? '0 : arith(m_op);
      end
   endtask

   task automatic drain(input int limit);
      int guard = 0;
      while ((q[0].size() + q[1].size() + q[2].size() > 0 || cyc < m_free) && guard < limit) begin
         step();
         guard++;
      end
      check("drain_bound", 64'(guard < limit), 64'(1));
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      add_done  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_zero();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push(input int r, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
      op_t op;
      op.sub = sub;
      op.a   = a;
      op.b   = b;
      q[r].push_back(op);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      int guard;
      reset      = 1'b1;
      req_valid  = '0;
      req_sub    = '0;
      req_a      = '0;
      req_b      = '0;
      add_done   = 1'b0;
      add_result = '0;
      do_reset();

      // Single add and single subtract with a 2-cycle adder.
      next_k = 2;
      push(0, 1'b0, W'(5), W'(3));
      drain(100);
      push(1, 1'b1, W'(3), W'(5));
      drain(100);

      // Stray add_done while idle must not produce a response.
      stray_en = 1'b1;
      repeat (8) step();
      stray_en = 1'b0;

      // Fairness: two requesters held continuously after reset.
      do_reset();
      next_k = 1;
      dut_log.delete();
      for (int i = 0; i < 3; i++) begin
         push(0, 1'b0, W'($urandom), W'($urandom));
         push(1, 1'b1, W'($urandom), W'($urandom));
      end
      drain(200);
      check("fair_count", 64'(dut_log.size()), 64'(6));
      for (int i = 0; i < 6; i++) begin
         if (i < dut_log.size()) check("fair_order", 64'(dut_log[i]), 64'(i % 2));
      end

      // Timeout abort, then add_done on the exact timeout cycle.
      next_k = 0;
      push(2, 1'b0, W'(100), W'(23));
      drain(100);
      next_k = TO + 1;
      push(0, 1'b1, W'(77), W'(11));
      drain(100);

      // Reset during WAIT: nothing must respond; next grant goes to requester 0.
      next_k = 0;
      push(1, 1'b1, W'(16'h1234), W'(16'h0F0F));
      guard = 0;
      while (!(m_issue >= 0 && cyc == m_issue + 1) && guard < 40) begin
         step();
         guard++;
      end
      check("wait_reached", 64'(guard < 40), 64'(1));
      req_valid = '0;
      #1 reset = 1'b1;
      #1;
      check_zero();
      model_reset();
      add_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      next_k = 2;
      dut_log.delete();
      push(2, 1'b0, W'(1), W'(2));
      push(0, 1'b0, W'(3), W'(4));
      drain(100);
      check("post_reset_cnt", 64'(dut_log.size()), 64'(2));
      if (dut_log.size() > 0) check("post_reset_first", 64'(dut_log[0]), 64'(0));

      // Randomized traffic with random valid gaps, latencies and stray dones.
      next_k     = -1;
      rand_valid = 1'b1;
      stray_en   = 1'b1;
      for (int i = 0; i < 60; i++) begin
         push($urandom_range(N - 1), 1'($urandom), W'($urandom), W'($urandom));
      end
      drain(5000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
